// File: rtl/fdsync24_pkg.sv
// rtl/fdsync24_pkg.sv - shared constants and FSM state type for the fdsync24 write controller
package fdsync24_pkg;

  localparam int WIDTH = 24;
  localparam int NREQ  = 3;
  localparam logic [WIDTH-1:0] RESET_VAL = 24'h000000;

  typedef enum logic {
    IDLE = 1'b0,
    COOL = 1'b1
  } state_t;

endpackage

// File: rtl/fdsync24_ctrl_rr_arb3.sv
// rtl/fdsync24_ctrl_rr_arb3.sv - three-way round-robin arbiter with registered priority pointer
module rr_arb3 (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       en,
  output logic [2:0] gnt,
  output logic       any
);

  logic [1:0] ptr;

  assign any = |req;

  // Search order starts at ptr and wraps; encoding 2'd3 is unreachable and falls back to 0.
  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd1: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 2'd0;
    end else if (en && any) begin
      if (gnt[0])      ptr <= 2'd1;
      else if (gnt[1]) ptr <= 2'd2;
      else             ptr <= 2'd0;
    end
  end

endmodule

// File: rtl/fdsync24_ctrl.sv
// rtl/fdsync24_ctrl.sv - arbitrated staging register with sync/bypass commit into the active register
module fdsync24_ctrl #(
  parameter int WIDTH = fdsync24_pkg::WIDTH,
  parameter int NREQ  = fdsync24_pkg::NREQ,
  parameter logic [WIDTH-1:0] RESET_VAL = fdsync24_pkg::RESET_VAL
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic [NREQ-1:0]  ack,
  input  logic             sync,
  input  logic             imm,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] stage,
  output logic             pending,
  output logic             ld,
  output logic             overrun
);

  import fdsync24_pkg::*;

  state_t           state;
  logic [2:0]       gnt;
  logic             any;
  logic             grant;
  logic             commit;
  logic [WIDTH-1:0] din_sel;

  rr_arb3 u_arb (
    .clk   (sys_clk),
    .reset (reset),
    .req   (req),
    .en    (state == IDLE),
    .gnt   (gnt),
    .any   (any)
  );

  assign grant  = (state == IDLE) && any;
  assign commit = (sync || imm) && pending;

  always_comb begin
    din_sel = din0;
    if (gnt[1]) din_sel = din1;
    if (gnt[2]) din_sel = din2;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= IDLE;
      ack     <= '0;
      ld      <= 1'b0;
      q       <= RESET_VAL;
      stage   <= RESET_VAL;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ack <= grant ? gnt : '0;
      ld  <= commit;
      if (commit) q <= stage;
      if (grant) stage <= din_sel;
      // A grant coinciding with a commit leaves the new data pending but loses nothing.
      pending <= grant || (pending && !commit);
      if (grant && pending && !commit) overrun <= 1'b1;
      else if (clr_ovr)                overrun <= 1'b0;
      case (state)
        IDLE:    if (grant) state <= COOL;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
